// File: rtl/deserializer.sv
// Receive-side deframer: validates the header beat of each Aurora RX frame,
// reassembles the payload beats and emits one packet pulse per good frame.
module deserializer #(
    parameter int AURORA_DATA_WIDTH      = 64,
    parameter int HOST_PAYLOAD_WIDTH     = 256,
    parameter int RECOGNIZE_HEADER_WIDTH = 8,
    parameter logic [RECOGNIZE_HEADER_WIDTH-1:0] RECOGNIZE_HEADER_VALUE = 8'hA5,
    parameter int RECOGNIZE_ROUTER_WIDTH = 8,
    parameter int ADDR_WIDTH             = 16,
    parameter int TTL_WIDTH              = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              axis_rx_tvalid,
    input  logic                              axis_rx_tlast,
    input  logic [AURORA_DATA_WIDTH-1:0]      axis_rx_tdata,
    output logic                              recv_data_valid,
    output logic [HOST_PAYLOAD_WIDTH-1:0]     v_data_recv,
    output logic [ADDR_WIDTH-1:0]             dst_addr_recv,
    output logic [TTL_WIDTH-1:0]              TTL_recv,
    output logic [RECOGNIZE_ROUTER_WIDTH-1:0] router_id_recv,
    output logic                              frame_error,
    output logic                              ttl_drop
);
    localparam int BEATS = HOST_PAYLOAD_WIDTH / AURORA_DATA_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, PAYLOAD, DISCARD} state_t;

    state_t                            state_reg, state_next;
    logic [CNT_W-1:0]                  beat_cnt_reg, beat_cnt_next;
    logic [HOST_PAYLOAD_WIDTH-1:0]     payload_sh_reg, payload_sh_next;
    logic [RECOGNIZE_ROUTER_WIDTH-1:0] rid_sh_reg, rid_sh_next;
    logic [ADDR_WIDTH-1:0]             addr_sh_reg, addr_sh_next;
    logic [TTL_WIDTH-1:0]              ttl_sh_reg, ttl_sh_next;

    logic [HOST_PAYLOAD_WIDTH-1:0]     data_out_reg, data_out_next;
    logic [RECOGNIZE_ROUTER_WIDTH-1:0] rid_out_reg, rid_out_next;
    logic [ADDR_WIDTH-1:0]             addr_out_reg, addr_out_next;
    logic [TTL_WIDTH-1:0]              ttl_out_reg, ttl_out_next;
    logic                              valid_reg, valid_next;
    logic                              error_reg, error_next;
    logic                              drop_reg, drop_next;

    // Header fields are packed from the MSB downward; reserved LSBs are ignored.
    logic [RECOGNIZE_HEADER_WIDTH-1:0] hdr_magic;
    logic [RECOGNIZE_ROUTER_WIDTH-1:0] hdr_rid;
    logic [ADDR_WIDTH-1:0]             hdr_addr;
    logic [TTL_WIDTH-1:0]              hdr_ttl;
    logic                              magic_ok;
    logic [HOST_PAYLOAD_WIDTH-1:0]     payload_shifted;

    assign hdr_magic = axis_rx_tdata[AURORA_DATA_WIDTH-1 -: RECOGNIZE_HEADER_WIDTH];
    assign hdr_rid   = axis_rx_tdata[AURORA_DATA_WIDTH-RECOGNIZE_HEADER_WIDTH-1 -: RECOGNIZE_ROUTER_WIDTH];
    assign hdr_addr  = axis_rx_tdata[AURORA_DATA_WIDTH-RECOGNIZE_HEADER_WIDTH-RECOGNIZE_ROUTER_WIDTH-1 -: ADDR_WIDTH];
    assign hdr_ttl   = axis_rx_tdata[AURORA_DATA_WIDTH-RECOGNIZE_HEADER_WIDTH-RECOGNIZE_ROUTER_WIDTH-ADDR_WIDTH-1 -: TTL_WIDTH];
    assign magic_ok  = (hdr_magic == RECOGNIZE_HEADER_VALUE);

    // First payload beat ends up in the MSBs after BEATS shifts.
    generate
        if (BEATS > 1) begin : g_shift
            assign payload_shifted = {payload_sh_reg[HOST_PAYLOAD_WIDTH-AURORA_DATA_WIDTH-1:0], axis_rx_tdata};
        end else begin : g_single
            assign payload_shifted = axis_rx_tdata;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            beat_cnt_reg   <= '0;
            payload_sh_reg <= '0;
            rid_sh_reg     <= '0;
            addr_sh_reg    <= '0;
            ttl_sh_reg     <= '0;
            data_out_reg   <= '0;
            rid_out_reg    <= '0;
            addr_out_reg   <= '0;
            ttl_out_reg    <= '0;
            valid_reg      <= 1'b0;
            error_reg      <= 1'b0;
            drop_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            beat_cnt_reg   <= beat_cnt_next;
            payload_sh_reg <= payload_sh_next;
            rid_sh_reg     <= rid_sh_next;
            addr_sh_reg    <= addr_sh_next;
            ttl_sh_reg     <= ttl_sh_next;
            data_out_reg   <= data_out_next;
            rid_out_reg    <= rid_out_next;
            addr_out_reg   <= addr_out_next;
            ttl_out_reg    <= ttl_out_next;
            valid_reg      <= valid_next;
            error_reg      <= error_next;
            drop_reg       <= drop_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        beat_cnt_next   = beat_cnt_reg;
        payload_sh_next = payload_sh_reg;
        rid_sh_next     = rid_sh_reg;
        addr_sh_next    = addr_sh_reg;
        ttl_sh_next     = ttl_sh_reg;
        data_out_next   = data_out_reg;
        rid_out_next    = rid_out_reg;
        addr_out_next   = addr_out_reg;
        ttl_out_next    = ttl_out_reg;
        valid_next      = 1'b0;
        error_next      = 1'b0;
        drop_next       = 1'b0;

        if (axis_rx_tvalid) begin
            case (state_reg)
                IDLE: begin
                    if (magic_ok && !axis_rx_tlast) begin
                        rid_sh_next   = hdr_rid;
                        addr_sh_next  = hdr_addr;
                        ttl_sh_next   = hdr_ttl;
                        beat_cnt_next = '0;
                        state_next    = PAYLOAD;
                    end else begin
                        error_next = 1'b1;
                        state_next = (!magic_ok && !axis_rx_tlast) ? DISCARD : IDLE;
                    end
                end
                PAYLOAD: begin
                    payload_sh_next = payload_shifted;
                    if (beat_cnt_reg == LAST_BEAT) begin
                        if (axis_rx_tlast) begin
                            state_next = IDLE;
                            if (ttl_sh_reg == '0) begin
                                drop_next = 1'b1;
                            end else begin
                                data_out_next = payload_shifted;
                                rid_out_next  = rid_sh_reg;
                                addr_out_next = addr_sh_reg;
                                ttl_out_next  = ttl_sh_reg;
                                valid_next    = 1'b1;
                            end
                        end else begin
                            error_next = 1'b1;
                            state_next = DISCARD;
                        end
                    end else begin
                        beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                        if (axis_rx_tlast) begin
                            error_next = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (axis_rx_tlast) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign recv_data_valid = valid_reg;
    assign v_data_recv     = data_out_reg;
    assign dst_addr_recv   = addr_out_reg;
    assign TTL_recv        = ttl_out_reg;
    assign router_id_recv  = rid_out_reg;
    assign frame_error     = error_reg;
    assign ttl_drop        = drop_reg;
endmodule
